// File: rtl/push_pop_sequencer_pkg.sv
// Shared definitions for the PUSH/POP micro-op sequencer.
//   WORD, ADDR_WIDTH       : datapath word and register-address widths
//   SP/LR/PC_ADDR          : architectural register numbers used by list expansion
//   PUSH_OPCODE/POP_OPCODE : instr[15:9] patterns of 16-bit Thumb PUSH/POP
//   uop_kind_t             : micro-op kind presented to the register file and execute
//   seq_state_e            : sequencer FSM states
package push_pop_sequencer_pkg;

    localparam int unsigned WORD       = 32;
    localparam int unsigned ADDR_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] SP_ADDR = 4'd13;
    localparam logic [ADDR_WIDTH-1:0] LR_ADDR = 4'd14;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = 4'd15;

    localparam logic [6:0] PUSH_OPCODE = 7'b1011010;
    localparam logic [6:0] POP_OPCODE  = 7'b1011110;

    typedef enum logic [1:0] {
        UopPass  = 2'd0,
        UopStore = 2'd1,
        UopLoad  = 2'd2,
        UopSpAdj = 2'd3
    } uop_kind_t;

    typedef enum logic {
        StIdle = 1'b0,
        StSeq  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/reg_list_scan.sv
// Combinational scan of an 8-bit low-register list.
//   mask_i    : remaining register list
//   found_o   : at least one bit set
//   idx_o     : index of the lowest set bit (0 when mask_i is empty)
//   cleared_o : mask_i with its lowest set bit cleared
//   count_o   : number of set bits
module reg_list_scan (
    input  logic [7:0] mask_i,
    output logic       found_o,
    output logic [2:0] idx_o,
    output logic [7:0] cleared_o,
    output logic [3:0] count_o
);

    always_comb begin
        idx_o   = 3'd0;
        count_o = 4'd0;
        // Walk downwards so the last hit is the lowest set bit.
        for (int i = 7; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, mask_i[i]};
        end
    end

    assign found_o   = |mask_i;
    assign cleared_o = mask_i & (mask_i - 8'd1);

endmodule

// File: rtl/push_pop_sequencer.sv
// Decode-side sequencer expanding Thumb PUSH/POP register lists into single-register uops.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   instr_i/instr_valid_i   : instruction from fetch, with its address pc_i
//   instr_ready_o           : instruction accepted this cycle when valid is also high
//   stall_i                 : hold every output and all internal state
//   flush_i                 : discard current and pending uops
//   uop_*_o, pc_o           : registered uop stream (kind, register, SP offset, source instr, last)
module push_pop_sequencer
    import push_pop_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 16,
    parameter int unsigned OFFSET_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [INSTR_WIDTH-1:0]  instr_i,
    input  logic                    instr_valid_i,
    input  logic [WORD-1:0]         pc_i,
    output logic                    instr_ready_o,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic                    uop_valid_o,
    output logic [1:0]              uop_kind_o,
    output logic [ADDR_WIDTH-1:0]   uop_reg_o,
    output logic [OFFSET_WIDTH-1:0] uop_offset_o,
    output logic [INSTR_WIDTH-1:0]  uop_instr_o,
    output logic                    uop_last_o,
    output logic [WORD-1:0]         pc_o
);

    // FSM state: StSeq means uops remain to be issued after the one on the outputs.
    seq_state_e state_q, state_d;

    // Remaining-work context of the list being expanded.
    logic [7:0] mask_q, mask_d;    // low registers not yet issued
    logic       extra_q, extra_d;  // LR (PUSH) or PC (POP) still pending
    logic       adj_q, adj_d;      // SP adjust still pending
    logic       push_q, push_d;
    logic [3:0] k_q, k_d;          // index of the next memory uop
    logic [3:0] n_q, n_d;          // total registers transferred

    // Registered uop outputs.
    logic                    valid_q, valid_d;
    uop_kind_t               kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]   reg_q, reg_d;
    logic [OFFSET_WIDTH-1:0] off_q, off_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    last_q, last_d;
    logic [WORD-1:0]         pc_q, pc_d;

    // Decode of the incoming instruction.
    logic is_push, is_pop, is_list, accept;

    assign is_push = (instr_i[15:9] == PUSH_OPCODE);
    assign is_pop  = (instr_i[15:9] == POP_OPCODE);
    assign is_list = is_push || is_pop;

    assign instr_ready_o = rst_n_i && !stall_i && !flush_i &&
                           ((state_q == StIdle) || (valid_q && last_q));
    assign accept        = instr_valid_i && instr_ready_o;

    // Generator context: a freshly accepted list in StIdle, otherwise the stored remainder.
    logic       src_new;
    logic [7:0] src_mask;
    logic       src_extra, src_adj, src_push;
    logic [3:0] src_k, src_n;

    logic       scan_found;
    logic [2:0] scan_idx;
    logic [7:0] scan_cleared;
    logic [3:0] scan_count;

    assign src_new   = (state_q == StIdle);
    assign src_mask  = src_new ? instr_i[7:0] : mask_q;
    assign src_extra = src_new ? instr_i[8]   : extra_q;
    assign src_adj   = src_new ? 1'b1         : adj_q;
    assign src_push  = src_new ? is_push      : push_q;
    assign src_k     = src_new ? 4'd0         : k_q;
    assign src_n     = src_new ? (scan_count + {3'b000, instr_i[8]}) : n_q;

    reg_list_scan u_scan (
        .mask_i    (src_mask),
        .found_o   (scan_found),
        .idx_o     (scan_idx),
        .cleared_o (scan_cleared),
        .count_o   (scan_count)
    );

    // Byte offsets 4*n and 4*k in offset-width two's complement.
    logic [OFFSET_WIDTH-1:0] n4, k4;

    assign n4 = OFFSET_WIDTH'({src_n, 2'b00});
    assign k4 = OFFSET_WIDTH'({src_k, 2'b00});

    // Next uop of the list and the context left after issuing it.
    uop_kind_t               gen_kind;
    logic [ADDR_WIDTH-1:0]   gen_reg;
    logic [OFFSET_WIDTH-1:0] gen_off;
    logic                    gen_last;
    logic [7:0]              gen_mask;
    logic                    gen_extra, gen_adj;
    logic [3:0]              gen_k;

    always_comb begin
        gen_kind  = UopPass;
        gen_reg   = '0;
        gen_off   = '0;
        gen_last  = 1'b0;
        gen_mask  = src_mask;
        gen_extra = src_extra;
        gen_adj   = src_adj;
        gen_k     = src_k;
        if (scan_found) begin
            // Low registers first, ascending.
            gen_kind = src_push ? UopStore : UopLoad;
            gen_reg  = {1'b0, scan_idx};
            gen_off  = src_push ? (k4 - n4) : k4;
            gen_mask = scan_cleared;
            gen_k    = src_k + 4'd1;
        end else if (src_push && src_extra) begin
            // LR occupies the highest slot just below the old SP.
            gen_kind  = UopStore;
            gen_reg   = LR_ADDR;
            gen_off   = k4 - n4;
            gen_extra = 1'b0;
            gen_k     = src_k + 4'd1;
        end else if (src_adj) begin
            gen_kind = UopSpAdj;
            gen_off  = src_push ? (OFFSET_WIDTH'(0) - n4) : n4;
            gen_adj  = 1'b0;
            gen_last = src_push || !src_extra;
        end else begin
            // POP {..., pc}: SP already moved up, so PC sits one word below it.
            gen_kind  = UopLoad;
            gen_reg   = PC_ADDR;
            gen_off   = OFFSET_WIDTH'(-4);
            gen_extra = 1'b0;
            gen_last  = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else if (!stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (accept && is_list && !gen_last) begin
                        state_d = StSeq;
                    end
                end
                StSeq: begin
                    if (gen_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Uop outputs and list context.
    always_comb begin
        valid_d = valid_q;
        kind_d  = kind_q;
        reg_d   = reg_q;
        off_d   = off_q;
        instr_d = instr_q;
        last_d  = last_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        extra_d = extra_q;
        adj_d   = adj_q;
        push_d  = push_q;
        k_d     = k_q;
        n_d     = n_q;
        if (flush_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            mask_d  = '0;
            extra_d = 1'b0;
            adj_d   = 1'b0;
        end else if (!stall_i) begin
            if (state_q == StSeq) begin
                valid_d = 1'b1;
                kind_d  = gen_kind;
                reg_d   = gen_reg;
                off_d   = gen_off;
                last_d  = gen_last;
                mask_d  = gen_mask;
                extra_d = gen_extra;
                adj_d   = gen_adj;
                k_d     = gen_k;
            end else if (accept) begin
                valid_d = 1'b1;
                instr_d = instr_i;
                pc_d    = pc_i;
                if (is_list) begin
                    kind_d  = gen_kind;
                    reg_d   = gen_reg;
                    off_d   = gen_off;
                    last_d  = gen_last;
                    mask_d  = gen_mask;
                    extra_d = gen_extra;
                    adj_d   = gen_adj;
                    push_d  = is_push;
                    k_d     = gen_k;
                    n_d     = src_n;
                end else begin
                    kind_d = UopPass;
                    reg_d  = '0;
                    off_d  = '0;
                    last_d = 1'b1;
                end
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            kind_q  <= UopPass;
            reg_q   <= '0;
            off_q   <= '0;
            instr_q <= '0;
            last_q  <= 1'b0;
            pc_q    <= '0;
            mask_q  <= '0;
            extra_q <= 1'b0;
            adj_q   <= 1'b0;
            push_q  <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            valid_q <= valid_d;
            kind_q  <= kind_d;
            reg_q   <= reg_d;
            off_q   <= off_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            extra_q <= extra_d;
            adj_q   <= adj_d;
            push_q  <= push_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

    assign uop_valid_o  = valid_q;
    assign uop_kind_o   = kind_q;
    assign uop_reg_o    = reg_q;
    assign uop_offset_o = off_q;
    assign uop_instr_o  = instr_q;
    assign uop_last_o   = last_q;
    assign pc_o         = pc_q;

endmodule
